// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR types and default sizing for fir_n and its coefficient loader
package fir_pkg;

    localparam int FIR_DEFAULT_N      = 32;
    localparam int FIR_DEFAULT_DELAYS = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } fir_coef_state_t;

endpackage

// File: rtl/fir_coef_shadow.sv
// rtl/fir_coef_shadow.sv - indexed write bank of DELAYS+1 coefficient registers, flattened read-out
module fir_coef_shadow
    import fir_pkg::*;
#(
    parameter int DELAYS = FIR_DEFAULT_DELAYS,
    parameter int N      = FIR_DEFAULT_N
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we,
    input  logic [$clog2(DELAYS+1)-1:0]   widx,
    input  logic [N-1:0]                  wdata,
    output logic [(DELAYS+1)*N-1:0]       bank_flat
);

    localparam int IW = $clog2(DELAYS + 1);

    logic [N-1:0] bank_q [DELAYS+1];
    logic [N-1:0] bank_d [DELAYS+1];

    always_comb begin
        bank_d = bank_q;
        for (int k = 0; k <= DELAYS; k++) begin
            if (we && widx == IW'(k)) begin
                bank_d[k] = wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q <= '{default: '0};
        end else begin
            bank_q <= bank_d;
        end
    end

    for (genvar k = 0; k <= DELAYS; k++) begin : g_flat
        assign bank_flat[k*N +: N] = bank_q[k];
    end

endmodule

// File: rtl/fir_coef_loader.sv
// rtl/fir_coef_loader.sv - loads FIR taps into a shadow bank and swaps the full set onto the live bus.
// FIR_COEF_AUTO_COMMIT_EN: publish automatically on the last tap instead of waiting for commit.
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter int DELAYS = FIR_DEFAULT_DELAYS,
    parameter int N      = FIR_DEFAULT_N
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              coef_in,
    input  logic                      coef_valid,
    output logic                      coef_ready,
    input  logic                      commit,
    input  logic                      abort,
    output logic [(DELAYS+1)*N-1:0]   b_out,
    output logic                      b_update,
    output logic                      commit_err
);

    localparam int IW = $clog2(DELAYS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DELAYS);

    fir_coef_state_t             state_q, state_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [(DELAYS+1)*N-1:0]     b_out_q, b_out_d;
    logic                        b_update_q, b_update_d;
    logic                        commit_err_q, commit_err_d;
    logic [(DELAYS+1)*N-1:0]     shadow_bus;
    logic                        shadow_we;
    logic                        transfer;

    // Ready comes from registered state only, never from coef_valid.
    assign coef_ready = (state_q != FULL);
    assign transfer   = coef_valid && coef_ready;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        b_out_d      = b_out_q;
        b_update_d   = 1'b0;
        commit_err_d = 1'b0;
        shadow_we    = 1'b0;

        if (abort) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            if (transfer) begin
                shadow_we = 1'b1;
                idx_d     = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
`ifdef FIR_COEF_AUTO_COMMIT_EN
                    b_out_d              = shadow_bus;
                    b_out_d[DELAYS*N +: N] = coef_in;
                    b_update_d           = 1'b1;
                    state_d              = IDLE;
                    idx_d                = '0;
`else
                    state_d = FULL;
`endif
                end else begin
                    state_d = LOAD;
                end
            end

            if (state_q == FULL && commit) begin
                b_out_d    = shadow_bus;
                b_update_d = 1'b1;
                state_d    = IDLE;
                idx_d      = '0;
            end
`ifndef FIR_COEF_AUTO_COMMIT_EN
            if (state_q != FULL && commit) begin
                commit_err_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            b_out_q      <= '0;
            b_update_q   <= 1'b0;
            commit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            b_out_q      <= b_out_d;
            b_update_q   <= b_update_d;
            commit_err_q <= commit_err_d;
        end
    end

    fir_coef_shadow #(
        .DELAYS (DELAYS),
        .N      (N)
    ) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .we        (shadow_we),
        .widx      (idx_q),
        .wdata     (coef_in),
        .bank_flat (shadow_bus)
    );

    assign b_out      = b_out_q;
    assign b_update   = b_update_q;
    assign commit_err = commit_err_q;

endmodule

// File: doc/fir_coef_loader.md
# fir_coef_loader

Writer side of the FIR coefficient bus: accepts taps one at a time over a valid/ready stream, assembles them in a shadow bank, and on commit swaps the full set onto the `(DELAYS+1)*N`-bit `b` bus that `fir_n` reads. The live bus never shows a partially loaded set, so the filter can keep running during a reload. Sits between the control/host logic and `fir_n.b`, in the `clk_d` (sample) domain.

## Interface
- `DELAYS`, 3, number of delay blocks in the driven filter; tap count is DELAYS+1; must be >= 2
- `N`, 32, coefficient width in bits
- `clk`  in  1  sole clock; connect to the filter's `clk_d`
- `rst`  in  1  asynchronous, active-high reset
- `coef_in`  in  N  next coefficient, tap 0 first
- `coef_valid`  in  1  `coef_in` is valid this cycle
- `coef_ready`  out  1  loader accepts `coef_in` this cycle
- `commit`  in  1  single-cycle request to publish the shadow set
- `abort`  in  1  discard the partially or fully loaded shadow set
- `b_out`  out  (DELAYS+1)*N  live coefficient bus to `fir_n.b`; tap k at `[(k+1)*N-1 : k*N]`
- `b_update`  out  1  one-cycle pulse in the cycle `b_out` first shows a new set
- `commit_err`  out  1  one-cycle pulse when a `commit` is rejected

## Operation
- A transfer occurs on a rising edge where `coef_valid && coef_ready`.
- Write index `idx` ranges 0..DELAYS. A transfer writes `shadow[idx]`, then increments `idx`.
- States:
  - IDLE: `coef_ready`=1, `idx`=0. A transfer moves the FSM to LOAD.
  - LOAD: `coef_ready`=1. A transfer with `idx`==DELAYS moves the FSM to FULL.
  - FULL: `coef_ready`=0. `commit` copies all taps from shadow to `b_out`, then the FSM moves to IDLE with `idx`=0.
- `commit` in IDLE or LOAD:
  - Ignored; no state change.
  - `commit_err` pulses on the next cycle.
- `abort` in any state: FSM goes to IDLE and `idx` clears. Shadow contents are don't-care. `b_out` is unchanged.
- `abort` and `commit` in the same cycle: `abort` wins. No swap, no `b_update`, no `commit_err`.
- `abort` and a transfer in the same cycle: `abort` wins and the coefficient is dropped.
- Coefficients are stored verbatim; no arithmetic, no sign handling.
- `coef_valid` may stay high across FULL; no data is lost because `coef_ready`=0 there.

## Timing
- Reset values (asynchronous):
  - state IDLE, `idx`=0
  - `b_out`=0 (all-zero filter, output 0)
  - `b_update`=0, `commit_err`=0
  - `coef_ready`=1 immediately on reset release
- `coef_ready` is decoded from the registered state only. It has no combinational path from `coef_valid`.
- Load throughput: one tap per cycle. A full set takes DELAYS+1 cycles of back-to-back transfers.
- Commit latency: `commit` sampled high in FULL at edge t. `b_out` shows the new set after edge t, and `b_update`=1 for exactly that one cycle.
- Earliest reload: a new transfer is accepted in the cycle right after the commit edge.
- Reset mid-load or while FULL: everything returns to reset values, including `b_out`=0.

## Configuration
- `FIR_COEF_AUTO_COMMIT_EN` defined:
  - The transfer of tap DELAYS copies shadow plus the incoming tap to `b_out` on that same edge.
  - `b_update` pulses in the following cycle and the FSM goes directly to IDLE. FULL is unreachable.
  - `commit` is ignored and never raises `commit_err`. `abort` behaves as above.
- Not defined: explicit-commit behaviour as described in Operation.

## Structure
- Shared package `fir_pkg` holds the FSM enum type `fir_coef_state_t` (IDLE, LOAD, FULL) and the `FIR_DEFAULT_N`/`FIR_DEFAULT_DELAYS` constants used by both this block and `fir_n` instantiations.
- One natural sub-module, `fir_coef_shadow`: an indexed write bank of DELAYS+1 N-bit registers, with a flattened read-out bus. The FSM, index counter and live register stay in `fir_coef_loader`.

## Test plan
All cases use DELAYS=3, N=32.
- Reset, then stream 1,2,3,4 back-to-back, then `commit` one cycle later:
  - `coef_ready` drops after the 4th transfer.
  - `b_out` = {4,3,2,1} (tap0=1) one cycle after `commit`, with `b_update` high for 1 cycle.
- `commit` after only 2 taps loaded:
  - `commit_err` pulses once.
  - `b_out` stays 0.
  - Loading 2 more taps plus `commit` then publishes all 4.
- Live set {4,3,2,1}; load 9,9,9, then assert `abort` together with the 4th tap 9:
  - `b_out` stays {4,3,2,1}.
  - Next load of 5,6,7,8 plus `commit` gives {8,7,6,5}.
- FULL with `commit` and `abort` asserted together: no `b_update`, FSM IDLE, `b_out` unchanged.
- Assert `rst` mid-load after 3 taps with a non-zero live set:
  - `b_out`=0 and `coef_ready`=1 immediately.
  - A subsequent full load starts at tap 0.
- With `FIR_COEF_AUTO_COMMIT_EN` defined, stream 10,20,30,40 with no `commit`:
  - `b_out`={40,30,20,10} after the 4th transfer edge.
  - `b_update` pulses once; `coef_ready` never drops.
